// File: rtl/axi4lite_mem_ctrl.sv
// AXI4-Lite slave sequencer for a single-cycle-write, registered-read word memory; write MEM_WEN@1/BVALID@2, read MEM_REN@1/RVALID@3.
// Independent write/read FSMs share the memory through a round-robin arbiter; stalled BREADY blocks only AW/W, stalled RREADY only AR.
module axi4lite_mem_ctrl #(
  parameter int dataWidth    = 32,
  parameter int dataDepth    = 64,
  parameter int memAddrWidth = $clog2(dataDepth),
  parameter int addrWidth    = 8,
  parameter int strbWidth    = dataWidth / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [addrWidth-1:0]    AWADDR,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [dataWidth-1:0]    WDATA,
  input  logic [strbWidth-1:0]    WSTRB,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [1:0]              BRESP,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [addrWidth-1:0]    ARADDR,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [dataWidth-1:0]    RDATA,
  output logic [1:0]              RRESP,
  output logic                    MEM_WEN,
  output logic [memAddrWidth-1:0] MEM_AWADDR,
  output logic [strbWidth-1:0]    MEM_WSTRB,
  output logic [dataWidth-1:0]    MEM_WDATA,
  output logic                    MEM_REN,
  output logic [memAddrWidth-1:0] MEM_ARADDR,
  input  logic [dataWidth-1:0]    MEM_RDATA
);

  typedef enum logic [1:0] {W_IDLE, W_ARB, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ARB, R_DATA, R_RESP} r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_e               w_state_q, w_state_d;
  logic                   aw_done_q, aw_done_d;
  logic                   wd_done_q, wd_done_d;
  logic [addrWidth-1:0]   awaddr_q, awaddr_d;
  logic [dataWidth-1:0]   wdata_q, wdata_d;
  logic [strbWidth-1:0]   wstrb_q, wstrb_d;
  logic                   awready_q, awready_d;
  logic                   wready_q, wready_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;

  r_state_e               r_state_q, r_state_d;
  logic [addrWidth-1:0]   araddr_q, araddr_d;
  logic                   arready_q, arready_d;
  logic                   rvalid_q, rvalid_d;
  logic [dataWidth-1:0]   rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;

  logic                   last_rd_q, last_rd_d;
  logic                   gnt_w, gnt_r;
  logic                   aw_oor, ar_oor;

  assign aw_oor = (awaddr_q >> (memAddrWidth + 2)) != '0;
  assign ar_oor = (araddr_q >> (memAddrWidth + 2)) != '0;

  // The last-grant flag only moves on contention, so a lone request never skews the next tie-break.
  always_comb begin
    gnt_w     = 1'b0;
    gnt_r     = 1'b0;
    last_rd_d = last_rd_q;
    if (w_state_q == W_ARB && r_state_q == R_ARB) begin
      gnt_w     = last_rd_q;
      gnt_r     = !last_rd_q;
      last_rd_d = !last_rd_q;
    end else begin
      gnt_w = (w_state_q == W_ARB);
      gnt_r = (r_state_q == R_ARB);
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    wd_done_d = wd_done_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (AWVALID && awready_q) begin
          aw_done_d = 1'b1;
          awaddr_d  = AWADDR;
        end
        if (WVALID && wready_q) begin
          wd_done_d = 1'b1;
          wdata_d   = WDATA;
          wstrb_d   = WSTRB;
        end
        if (aw_done_d && wd_done_d) w_state_d = W_ARB;
      end
      W_ARB: begin
        if (gnt_w) begin
          w_state_d = W_RESP;
          aw_done_d = 1'b0;
          wd_done_d = 1'b0;
          bresp_d   = aw_oor ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: begin
        if (BREADY && bvalid_q) begin
          w_state_d = W_IDLE;
          bresp_d   = RESP_OKAY;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_done_d;
    wready_d  = (w_state_d == W_IDLE) && !wd_done_d;
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID && arready_q) begin
          araddr_d  = ARADDR;
          r_state_d = R_ARB;
        end
      end
      R_ARB: if (gnt_r) r_state_d = R_DATA;
      R_DATA: begin
        rdata_d   = ar_oor ? '0 : MEM_RDATA;
        rresp_d   = ar_oor ? RESP_SLVERR : RESP_OKAY;
        r_state_d = R_RESP;
      end
      R_RESP: begin
        if (RREADY && rvalid_q) begin
          r_state_d = R_IDLE;
          rdata_d   = '0;
          rresp_d   = RESP_OKAY;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      aw_done_q <= 1'b0;
      wd_done_q <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      last_rd_q <= 1'b1;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      wd_done_q <= wd_done_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      last_rd_q <= last_rd_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

  // Gating with reset keeps the memory untouched in the very cycle reset is raised.
  assign MEM_WEN    = !reset && gnt_w && !aw_oor;
  assign MEM_AWADDR = MEM_WEN ? awaddr_q[memAddrWidth+1:2] : '0;
  assign MEM_WSTRB  = MEM_WEN ? wstrb_q : '0;
  assign MEM_WDATA  = MEM_WEN ? wdata_q : '0;
  assign MEM_REN    = !reset && gnt_r && !ar_oor;
  assign MEM_ARADDR = MEM_REN ? araddr_q[memAddrWidth+1:2] : '0;

endmodule

// File: tb/tb_axi4lite_mem_ctrl.sv
// Directed bench for axi4lite_mem_ctrl with a behavioural 64-word memory (byte strobes, registered read).
module tb_axi4lite_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        AWVALID, AWREADY;
  logic [8:0]  AWADDR;
  logic        WVALID, WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID, BREADY;
  logic [1:0]  BRESP;
  logic        ARVALID, ARREADY;
  logic [8:0]  ARADDR;
  logic        RVALID, RREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        MEM_WEN;
  logic [5:0]  MEM_AWADDR;
  logic [3:0]  MEM_WSTRB;
  logic [31:0] MEM_WDATA;
  logic        MEM_REN;
  logic [5:0]  MEM_ARADDR;
  logic [31:0] MEM_RDATA;

  logic [31:0] mem [64];
  logic        mem_clr;
  int          wen_cnt, ren_cnt;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          base_w, base_r;

  always #5 clk = ~clk;

  axi4lite_mem_ctrl #(.dataWidth(32), .dataDepth(64), .addrWidth(9)) dut (
    .clk(clk), .reset(reset),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .MEM_WEN(MEM_WEN), .MEM_AWADDR(MEM_AWADDR), .MEM_WSTRB(MEM_WSTRB), .MEM_WDATA(MEM_WDATA),
    .MEM_REN(MEM_REN), .MEM_ARADDR(MEM_ARADDR), .MEM_RDATA(MEM_RDATA)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      MEM_RDATA <= '0;
      wen_cnt   <= 0;
      ren_cnt   <= 0;
    end else begin
      if (MEM_WEN) begin
        wen_cnt <= wen_cnt + 1;
        for (int b = 0; b < 4; b++)
          if (MEM_WSTRB[b]) mem[MEM_AWADDR][8*b +: 8] <= MEM_WDATA[8*b +: 8];
      end
      if (MEM_REN) begin
        ren_cnt   <= ren_cnt + 1;
        MEM_RDATA <= mem[MEM_ARADDR];
      end
    end
  end

  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp);
    int k;
    AWVALID = 1'b1; AWADDR = a; WVALID = 1'b1; WDATA = d; WSTRB = s; BREADY = 1'b1;
    nxt;
    AWVALID = 1'b0; WVALID = 1'b0;
    k = 0;
    while (!BVALID && k < 10) begin nxt; k++; end
    chk("bvalid_wait", {31'd0, BVALID}, 32'd1);
    chk("bresp", {30'd0, BRESP}, {30'd0, resp});
    nxt;
  endtask

  task automatic do_read(input logic [8:0] a, input logic [31:0] d, input logic [1:0] resp);
    int k;
    ARVALID = 1'b1; ARADDR = a; RREADY = 1'b1;
    nxt;
    ARVALID = 1'b0;
    k = 0;
    while (!RVALID && k < 10) begin nxt; k++; end
    chk("rvalid_wait", {31'd0, RVALID}, 32'd1);
    chk("rdata", RDATA, d);
    chk("rresp", {30'd0, RRESP}, {30'd0, resp});
    nxt;
  endtask

  initial begin
    reset = 1'b1; mem_clr = 1'b1;
    AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0; BREADY = 1'b0;
    ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0;
    repeat (3) nxt;
    mem_clr = 1'b0;
    chk("reset_handshake", {25'd0, AWREADY, WREADY, BVALID, ARREADY, RVALID, MEM_WEN, MEM_REN}, 32'd0);
    chk("reset_resp", {28'd0, BRESP, RRESP}, 32'd0);
    chk("reset_rdata", RDATA, 32'd0);
    reset = 1'b0;
    nxt;
    chk("ready_after_reset", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);

    // Same-cycle AW/W, latency check, then readback with latency check
    AWVALID = 1'b1; AWADDR = 9'h010; WVALID = 1'b1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; BREADY = 1'b1;
    nxt;
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t1_wen_c1", {31'd0, MEM_WEN}, 32'd1);
    chk("t1_awaddr", {26'd0, MEM_AWADDR}, 32'd4);
    chk("t1_wdata", MEM_WDATA, 32'hDEADBEEF);
    chk("t1_wstrb", {28'd0, MEM_WSTRB}, 32'hF);
    chk("t1_bvalid_c1", {31'd0, BVALID}, 32'd0);
    nxt;
    chk("t1_bvalid_c2", {31'd0, BVALID}, 32'd1);
    chk("t1_bresp", {30'd0, BRESP}, 32'd0);
    chk("t1_wen_c2", {31'd0, MEM_WEN}, 32'd0);
    nxt;
    chk("t1_bvalid_c3", {31'd0, BVALID}, 32'd0);
    chk("t1_awready_c3", {31'd0, AWREADY}, 32'd1);
    ARVALID = 1'b1; ARADDR = 9'h010; RREADY = 1'b1;
    nxt;
    ARVALID = 1'b0;
    chk("t1_ren_c1", {31'd0, MEM_REN}, 32'd1);
    chk("t1_araddr", {26'd0, MEM_ARADDR}, 32'd4);
    nxt;
    chk("t1_rvalid_c2", {31'd0, RVALID}, 32'd0);
    nxt;
    chk("t1_rvalid_c3", {31'd0, RVALID}, 32'd1);
    chk("t1_rdata", RDATA, 32'hDEADBEEF);
    chk("t1_rresp", {30'd0, RRESP}, 32'd0);
    nxt;
    chk("t1_rvalid_drop", {31'd0, RVALID}, 32'd0);
    chk("t1_arready_back", {31'd0, ARREADY}, 32'd1);

    // W leads AW by three cycles
    base_w = wen_cnt;
    WVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF;
    nxt;
    WVALID = 1'b0;
    chk("t2_wready_low", {31'd0, WREADY}, 32'd0);
    chk("t2_awready_high", {31'd0, AWREADY}, 32'd1);
    nxt;
    chk("t2_no_wen", {31'd0, MEM_WEN}, 32'd0);
    nxt;
    AWVALID = 1'b1; AWADDR = 9'h024;
    nxt;
    AWVALID = 1'b0;
    chk("t2_wen", {31'd0, MEM_WEN}, 32'd1);
    chk("t2_awaddr", {26'd0, MEM_AWADDR}, 32'd9);
    nxt;
    chk("t2_bvalid", {31'd0, BVALID}, 32'd1);
    nxt;
    chk("t2_wen_count", wen_cnt - base_w, 32'd1);
    do_read(9'h024, 32'h12345678, 2'b00);

    // Reset, then simultaneous AW/W/AR contention twice
    reset = 1'b1;
    nxt; nxt;
    reset = 1'b0;
    nxt;
    AWVALID = 1'b1; AWADDR = 9'h020; WVALID = 1'b1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 9'h020; BREADY = 1'b1; RREADY = 1'b1;
    nxt;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("t3_c1_wen_ren", {30'd0, MEM_WEN, MEM_REN}, 32'd2);
    nxt;
    chk("t3_c2_wen_ren", {30'd0, MEM_WEN, MEM_REN}, 32'd1);
    chk("t3_c2_araddr", {26'd0, MEM_ARADDR}, 32'd8);
    chk("t3_c2_bvalid", {31'd0, BVALID}, 32'd1);
    nxt;
    nxt;
    chk("t3_rvalid", {31'd0, RVALID}, 32'd1);
    chk("t3_rdata_new", RDATA, 32'hCAFEF00D);
    nxt;
    AWVALID = 1'b1; AWADDR = 9'h028; WVALID = 1'b1; WDATA = 32'h11112222; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 9'h028;
    nxt;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("t3_2nd_read_first", {30'd0, MEM_WEN, MEM_REN}, 32'd1);
    nxt;
    chk("t3_2nd_write_next", {30'd0, MEM_WEN, MEM_REN}, 32'd2);
    nxt;
    chk("t3_2nd_both_valid", {30'd0, BVALID, RVALID}, 32'd3);
    chk("t3_2nd_rdata_old", RDATA, 32'd0);
    nxt;
    do_read(9'h028, 32'h11112222, 2'b00);

    // Partial strobe merge and zero strobe
    do_write(9'h030, 32'hAAAAAAAA, 4'hF, 2'b00);
    do_write(9'h030, 32'h00001234, 4'h3, 2'b00);
    do_read(9'h030, 32'hAAAA1234, 2'b00);
    base_w = wen_cnt;
    do_write(9'h03C, 32'hFFFFFFFF, 4'h0, 2'b00);
    chk("t4_zero_strb_wen", wen_cnt - base_w, 32'd1);
    do_read(9'h03C, 32'd0, 2'b00);

    // Out-of-range addresses
    base_w = wen_cnt; base_r = ren_cnt;
    do_write(9'h100, 32'h55555555, 4'hF, 2'b10);
    do_read(9'h100, 32'd0, 2'b10);
    chk("t5_no_wen", wen_cnt - base_w, 32'd0);
    chk("t5_no_ren", ren_cnt - base_r, 32'd0);
    do_read(9'h000, 32'd0, 2'b00);

    // BREADY stalled five cycles while a read completes
    BREADY = 1'b0;
    AWVALID = 1'b1; AWADDR = 9'h038; WVALID = 1'b1; WDATA = 32'h0BADCAFE; WSTRB = 4'hF;
    nxt;
    AWVALID = 1'b0; WVALID = 1'b0;
    nxt;
    for (int i = 0; i < 5; i++) begin
      chk("t6_bvalid_hold", {31'd0, BVALID}, 32'd1);
      chk("t6_awready_blocked", {31'd0, AWREADY}, 32'd0);
      if (i == 0) begin ARVALID = 1'b1; ARADDR = 9'h010; RREADY = 1'b1; end
      if (i == 1) begin
        ARVALID = 1'b0;
        chk("t6_ren", {31'd0, MEM_REN}, 32'd1);
      end
      if (i == 3) begin
        chk("t6_rvalid", {31'd0, RVALID}, 32'd1);
        chk("t6_rdata", RDATA, 32'hDEADBEEF);
      end
      if (i == 4) chk("t6_arready", {31'd0, ARREADY}, 32'd1);
      nxt;
    end
    chk("t6_bvalid_still", {31'd0, BVALID}, 32'd1);
    BREADY = 1'b1;
    nxt;
    chk("t6_bvalid_done", {31'd0, BVALID}, 32'd0);
    chk("t6_awready_back", {31'd0, AWREADY}, 32'd1);
    do_read(9'h038, 32'h0BADCAFE, 2'b00);

    // Reset raised while the read sits in R_DATA
    ARVALID = 1'b1; ARADDR = 9'h010;
    nxt;
    ARVALID = 1'b0;
    chk("t7_ren", {31'd0, MEM_REN}, 32'd1);
    nxt;
    reset = 1'b1;
    chk("t7_mem_gated", {30'd0, MEM_WEN, MEM_REN}, 32'd0);
    nxt;
    chk("t7_rvalid_arready", {30'd0, RVALID, ARREADY}, 32'd0);
    chk("t7_mem_ctrl", {16'd0, MEM_WEN, MEM_REN, MEM_AWADDR, MEM_ARADDR, MEM_WSTRB}, 32'd0);
    chk("t7_mem_wdata", MEM_WDATA, 32'd0);
    reset = 1'b0;
    nxt;
    nxt;
    chk("t7_after_reset", {30'd0, RVALID, ARREADY}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi4lite_mem_ctrl.md
Name: axi4lite_mem_ctrl

Overview:
- AXI4-Lite slave controller that sequences the single-cycle-write, registered-read word memory.
- Accepts independent read and write transactions.
- Arbitrates them onto the memory so that at most one of MEM_WEN/MEM_REN is high per cycle.
- Returns B/R responses. Sits between the interconnect and the memory instance inside the slave top.

Parameters:
- dataWidth, 32, data bus width (fixed 32; STRB is 4 bits).
- dataDepth, 64, memory words.
- memAddrWidth, $clog2(dataDepth), memory word-address width.
- addrWidth, 8, AXI byte-address width; must be at least memAddrWidth+2.
- strbWidth, dataWidth/8, write-strobe width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- AWVALID in 1 / AWREADY out 1 / AWADDR in addrWidth  write-address channel
- WVALID in 1 / WREADY out 1 / WDATA in dataWidth / WSTRB in strbWidth  write-data channel
- BVALID out 1 / BREADY in 1 / BRESP out 2  write-response channel
- ARVALID in 1 / ARREADY out 1 / ARADDR in addrWidth  read-address channel
- RVALID out 1 / RREADY in 1 / RDATA out dataWidth / RRESP out 2  read-data channel
- MEM_WEN out 1 / MEM_AWADDR out memAddrWidth / MEM_WSTRB out strbWidth / MEM_WDATA out dataWidth  memory write port
- MEM_REN out 1 / MEM_ARADDR out memAddrWidth  memory read port
- MEM_RDATA in dataWidth  memory read data, valid the cycle after MEM_REN

Behaviour:
- Reset: every output is 0 while reset is high, including all READY/VALID, RESP, RDATA and MEM_*. The arbiter's last-grant flag is set to "read", so the first contention grants write.
- Address map: word index = ADDR[memAddrWidth+1:2]. ADDR[1:0] is ignored. An address is out of range if ADDR[addrWidth-1:memAddrWidth+2] != 0.
- Write FSM states: W_IDLE, W_ARB, W_RESP.
  - W_IDLE: AWREADY=1 until AW is latched; WREADY=1 until W is latched. AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
  - Once both are latched, go to W_ARB.
  - W_ARB: on grant, MEM_WEN pulses for exactly 1 cycle with the latched address, strobe and data. If out of range, MEM_WEN stays 0 but the grant is still consumed. Go to W_RESP.
  - W_RESP: BVALID=1 and BRESP is held (OKAY=2'b00, SLVERR=2'b10) until BREADY. Then return to W_IDLE with AWREADY/WREADY high in the following cycle.
- Read FSM states: R_IDLE, R_ARB, R_DATA, R_RESP.
  - R_IDLE: ARREADY=1. A handshake latches ARADDR and moves to R_ARB.
  - R_ARB: on grant, MEM_REN pulses for 1 cycle (0 if out of range). Go to R_DATA.
  - R_DATA: RDATA is registered from MEM_RDATA, or 0 if out of range. Go to R_RESP.
  - R_RESP: RVALID=1; RDATA and RRESP are held stable until RREADY. Then return to R_IDLE.
- Arbiter:
  - One grant per cycle.
  - If only one FSM is in ARB, it is granted that cycle.
  - If both are in ARB, grant the opposite of the last grant (round-robin), then update the flag.
  - A loser stays in ARB and is granted next cycle. No starvation: worst-case wait is 1 cycle.
- Latency, no backpressure, no contention, handshake at cycle 0:
  - Write: MEM_WEN at cycle 1, BVALID at cycle 2.
  - Read: MEM_REN at cycle 1, RVALID at cycle 3.
- Ordering: a write granted before a read to the same address makes the read return the new data. There are no same-cycle read/write hazards because grants are exclusive.
- Backpressure: a stalled BREADY blocks new AW/W acceptance only; reads proceed. A stalled RREADY blocks only AR.
- All AXI outputs are registered. VALID never deasserts without its READY.
- Reset mid-transaction: all in-flight state is discarded. FSMs return to IDLE and nothing is written after reset asserts.
- WSTRB=0: MEM_WEN still pulses with a zero strobe, and the response is OKAY.

Test Plan:
- Write AWADDR=0x10, WDATA=0xDEADBEEF, WSTRB=0xF in the same cycle, BREADY=1. Expect MEM_WEN at cycle 1 with MEM_AWADDR=4, then BVALID/BRESP=00 at cycle 2. Read 0x10: expect RVALID at cycle 3 with RDATA=0xDEADBEEF and RRESP=00.
- W arrives 3 cycles before AW. Expect WREADY low after the W handshake, exactly one MEM_WEN after AW, and the correct data written.
- After reset, AW/W and AR to 0x20 complete their handshakes in the same cycle. Expect MEM_WEN at cycle 1 and MEM_REN at cycle 2. The read returns the newly written data. On a second simultaneous contention the read is granted first.
- Write WSTRB=0x3 with WDATA=0x0000_1234 over a word holding 0xAAAAAAAA. A readback returns 0xAAAA1234.
- AWADDR=0x100 (out of range for addrWidth=9) and ARADDR=0x100. Expect no MEM_WEN/MEM_REN, BRESP=10, RRESP=10 and RDATA=0.
- Hold BREADY=0 for 5 cycles. BVALID stays high, AWREADY stays low, and a concurrent read completes. Assert reset during R_DATA: the next cycle has RVALID=0, ARREADY=0 and all MEM_* at 0.
